// File: rtl/mips_cpu_muldiv_hilo.sv
// HI/LO register owner for the MIPS execute stage: multi-cycle shift-add multiply,
// restoring divide, and MTHI/MTLO writes, with a busy/done handshake for MFHI/MFLO stalls.
module mips_cpu_muldiv_hilo #(
   parameter int WIDTH    = 32,
   parameter int FAST_MUL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi_reg,
   output logic [WIDTH-1:0] lo_reg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic [1:0]         state_r;
   logic [CW-1:0]      cnt_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   opnd_r;
   logic               is_div_r;
   logic               neg_q_r;
   logic               neg_r_r;
   logic               dbz_r;
   logic               busy_r;
   logic               done_r;
   logic               dbz_pulse_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic               op_signed_s;
   logic               a_neg_s;
   logic               b_neg_s;
   logic [WIDTH-1:0]   abs_a_s;
   logic [WIDTH-1:0]   abs_b_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_next_s;
   logic [WIDTH:0]     div_diff_s;
   logic [2*WIDTH-1:0] div_next_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quo_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;
   logic [2*WIDTH-1:0] fast_mag_s;
   logic [2*WIDTH-1:0] fast_prod_s;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return {WIDTH{1'b0}} - v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return {(2*WIDTH){1'b0}} - v;
   endfunction

   // Operand magnitudes, one iteration step for each datapath, and sign-corrected results
   always_comb begin
      op_signed_s = (op == OP_MULT) || (op == OP_DIV);
      a_neg_s     = op_signed_s & operand_a[WIDTH-1];
      b_neg_s     = op_signed_s & operand_b[WIDTH-1];
      // The most negative value maps onto its unsigned magnitude 2^(WIDTH-1)
      abs_a_s     = a_neg_s ? neg_w(operand_a) : operand_a;
      abs_b_s     = b_neg_s ? neg_w(operand_b) : operand_b;

      mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                    (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};

      // Trial subtract of the divisor from the left-shifted partial remainder
      div_diff_s  = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
      div_next_s  = div_diff_s[WIDTH] ? {acc_r[2*WIDTH-2:0], 1'b0}
                                      : {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

      prod_fix_s  = neg_q_r ? neg_2w(acc_r) : acc_r;
      quo_fix_s   = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      rem_fix_s   = neg_r_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];

      fast_mag_s  = {{WIDTH{1'b0}}, abs_a_s} * {{WIDTH{1'b0}}, abs_b_s};
      fast_prod_s = (a_neg_s ^ b_neg_s) ? neg_2w(fast_mag_s) : fast_mag_s;
   end

   // Control FSM, iteration datapath and the architectural HI/LO registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= S_IDLE;
         cnt_r       <= {CW{1'b0}};
         acc_r       <= {(2*WIDTH){1'b0}};
         opnd_r      <= {WIDTH{1'b0}};
         is_div_r    <= 1'b0;
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
         dbz_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         dbz_pulse_r <= 1'b0;
         hi_r        <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
      end else begin
         done_r      <= 1'b0;
         dbz_pulse_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: hi_r <= operand_a;
                     OP_MTLO: lo_r <= operand_a;
                     OP_MULT, OP_MULTU: begin
                        if (FAST_MUL != 0) begin
                           {hi_r, lo_r} <= fast_prod_s;
                           done_r       <= 1'b1;
                        end else begin
                           // Multiplier sits in the low half and is consumed LSB first
                           acc_r    <= {{WIDTH{1'b0}}, abs_b_s};
                           opnd_r   <= abs_a_s;
                           is_div_r <= 1'b0;
                           neg_q_r  <= a_neg_s ^ b_neg_s;
                           neg_r_r  <= 1'b0;
                           dbz_r    <= 1'b0;
                           cnt_r    <= {CW{1'b0}};
                           busy_r   <= 1'b1;
                           state_r  <= S_RUN;
                        end
                     end
                     OP_DIV, OP_DIVU: begin
                        acc_r    <= {{WIDTH{1'b0}}, abs_a_s};
                        opnd_r   <= abs_b_s;
                        is_div_r <= 1'b1;
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        if (operand_b == {WIDTH{1'b0}}) begin
                           dbz_r   <= 1'b1;
                           state_r <= S_FIX;
                        end else begin
                           dbz_r   <= 1'b0;
                           state_r <= S_RUN;
                        end
                     end
                     default: state_r <= S_IDLE;
                  endcase
               end
            end
            S_RUN: begin
               acc_r <= is_div_r ? div_next_s : mul_next_s;
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == LAST_ITER) begin
                  state_r <= S_FIX;
               end
            end
            S_FIX: begin
               if (!dbz_r) begin
                  if (is_div_r) begin
                     hi_r <= rem_fix_s;
                     lo_r <= quo_fix_s;
                  end else begin
                     {hi_r, lo_r} <= prod_fix_s;
                  end
               end
               done_r      <= 1'b1;
               dbz_pulse_r <= dbz_r;
               busy_r      <= 1'b0;
               state_r     <= S_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dbz_pulse_r;
   assign hi_reg      = hi_r;
   assign lo_reg      = lo_r;

endmodule

// File: tb/tb_mips_cpu_muldiv_hilo.sv
// Directed bench for mips_cpu_muldiv_hilo: iterative instance plus a FAST_MUL=1 instance.
module tb_mips_cpu_muldiv_hilo;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        start_f;
   logic [2:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi_reg, lo_reg;
   logic        busy_f, done_f, dbz_f;
   logic [31:0] hi_f, lo_f;

   int tests_run    = 0;
   int tests_failed = 0;

   mips_cpu_muldiv_hilo #(.WIDTH(32), .FAST_MUL(0)) dut (
      .clk(clk), .reset(rst_n), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi_reg(hi_reg), .lo_reg(lo_reg)
   );

   mips_cpu_muldiv_hilo #(.WIDTH(32), .FAST_MUL(1)) dut_fast (
      .clk(clk), .reset(rst_n), .start(start_f), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy_f), .done(done_f), .div_by_zero(dbz_f),
      .hi_reg(hi_f), .lo_reg(lo_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pulses start for one accepting edge; returns at the negedge just after E0
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      @(negedge clk);
      start     = 1'b0;
      operand_a = 32'h0;
      operand_b = 32'h0;
   endtask

   // Issues an op and watches 50 cycles: first done cycle index, done and dbz pulse counts
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic busy0, output int lat, output int pulses, output int dbz_n);
      issue(o, a, b);
      busy0  = busy;
      lat    = 0;
      pulses = 0;
      dbz_n  = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (lat == 0) lat = i;
         end
         if (div_by_zero) dbz_n++;
      end
   endtask

   logic b0;
   int   lat, pulses, dbz_n;

   initial begin
      rst_n = 1'b0; start = 1'b0; start_f = 1'b0;
      op = 3'd7; operand_a = 32'h0; operand_b = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
      check("rst_hi",   {32'd0, hi_reg}, 64'd0);
      check("rst_lo",   {32'd0, lo_reg}, 64'd0);
      rst_n = 1'b1;

      issue(3'd4, 32'h12345678, 32'h0);
      check("mthi_hi",   {32'd0, hi_reg}, 64'h12345678);
      check("mthi_lo",   {32'd0, lo_reg}, 64'd0);
      check("mthi_busy", {63'd0, busy}, 64'd0);

      run_op(3'd0, 32'hFFFFFFFE, 32'h00000003, b0, lat, pulses, dbz_n);
      check("mult_busy", {63'd0, b0}, 64'd1);
      check("mult_lat", 64'(lat), 64'd33);
      check("mult_pulses", 64'(pulses), 64'd1);
      check("mult_hilo", {hi_reg, lo_reg}, 64'hFFFFFFFF_FFFFFFFA);

      run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, b0, lat, pulses, dbz_n);
      check("multu_lat", 64'(lat), 64'd33);
      check("multu_hilo", {hi_reg, lo_reg}, 64'h00000002_FFFFFFFA);

      @(negedge clk);
      start_f = 1'b1; op = 3'd1; operand_a = 32'hFFFFFFFE; operand_b = 32'h00000003;
      @(negedge clk);
      start_f = 1'b0;
      check("fast_done", {63'd0, done_f}, 64'd1);
      check("fast_busy", {63'd0, busy_f}, 64'd0);
      check("fast_hilo", {hi_f, lo_f}, 64'h00000002_FFFFFFFA);
      @(negedge clk);
      check("fast_done_once", {63'd0, done_f}, 64'd0);

      run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, b0, lat, pulses, dbz_n);
      check("div_m7_2_lat", 64'(lat), 64'd33);
      check("div_m7_2", {hi_reg, lo_reg}, 64'hFFFFFFFF_FFFFFFFD);

      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, b0, lat, pulses, dbz_n);
      check("div_min_m1", {hi_reg, lo_reg}, 64'h00000000_80000000);
      check("div_min_dbz", 64'(dbz_n), 64'd0);

      run_op(3'd2, 32'h00000007, 32'hFFFFFFFE, b0, lat, pulses, dbz_n);
      check("div_7_m2", {hi_reg, lo_reg}, 64'h00000001_FFFFFFFD);

      issue(3'd4, 32'h000000AA, 32'h0);
      issue(3'd5, 32'h000000BB, 32'h0);
      check("mtlo_keeps_hi", {hi_reg, lo_reg}, 64'h000000AA_000000BB);

      run_op(3'd3, 32'h00000005, 32'h00000000, b0, lat, pulses, dbz_n);
      check("dbz_busy", {63'd0, b0}, 64'd1);
      check("dbz_lat", 64'(lat), 64'd1);
      check("dbz_pulses", 64'(dbz_n), 64'd1);
      check("dbz_hilo", {hi_reg, lo_reg}, 64'h000000AA_000000BB);

      issue(3'd6, 32'h00000055, 32'h00000001);
      check("nop6_busy", {63'd0, busy}, 64'd0);
      check("nop6_hilo", {hi_reg, lo_reg}, 64'h000000AA_000000BB);

      // start asserted mid-operation must be ignored
      issue(3'd3, 32'd100, 32'd7);
      lat = 0; pulses = 0;
      for (int i = 1; i <= 50; i++) begin
         if (i == 5) begin
            start = 1'b1; op = 3'd4; operand_a = 32'hDEADBEEF; operand_b = 32'd0;
         end
         if (i == 8) start = 1'b0;
         @(negedge clk);
         if (done) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
      check("busy_ign_lat", 64'(lat), 64'd33);
      check("busy_ign_pulses", 64'(pulses), 64'd1);
      check("busy_ign_hilo", {hi_reg, lo_reg}, 64'h00000002_0000000E);

      issue(3'd3, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hilo", {hi_reg, lo_reg}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort_no_done", 64'(pulses), 64'd0);
      check("abort_idle", {63'd0, busy}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mips_cpu_muldiv_hilo.md
# mips_cpu_muldiv_hilo

Parametrised multi-cycle multiply/divide unit that owns the HI and LO architectural registers of the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and exposes HI/LO continuously for MFHI/MFLO. A busy/done handshake lets the control path stall on MFHI/MFLO while a long operation is in flight. It replaces the plain HI/LO register store in the execute stage.

## Interface
- WIDTH, 32: operand width and HI/LO register width; must be even and at least 4.
- FAST_MUL, 0: 1 = MULT/MULTU complete combinationally in one cycle; 0 = iterative, one bit per cycle.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- start  in  1  request an operation; sampled only when busy=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- operand_a  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO source.
- operand_b  in  WIDTH  rt value: multiplier or divisor.
- busy  out  1  operation in flight; new starts are ignored.
- done  out  1  one-cycle pulse when HI/LO have just been updated by a mul/div.
- div_by_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with operand_b=0.
- hi_reg  out  WIDTH  current HI.
- lo_reg  out  WIDTH  current LO.

## Operation
- Reset value of every output is 0: busy, done, div_by_zero, hi_reg, lo_reg. The FSM returns to IDLE.
- FSM states:
  - IDLE: accepts start.
  - RUN: iterates.
  - FIX: sign correction and HI/LO write.
  - Transitions: IDLE->RUN on a mul/div start; RUN->FIX after WIDTH iterations; FIX->IDLE unconditionally.
- MTHI/MTLO: with start=1 in IDLE, HI (or LO) <= operand_a at that edge. No busy, no done, and the other register is unchanged.
- Ops 6 and 7: ignored; no state change.
- Operand latch: operands and op are captured at the accepting edge. Later input changes have no effect.
- Signed ops: magnitudes |a| and |b| are computed at accept and the result signs are recorded. FIX negates as needed. |-2^(WIDTH-1)| is handled as the unsigned value 2^(WIDTH-1).
- Multiply (iterative): shift-add over a 2*WIDTH product register, one multiplier bit per RUN cycle. FIX writes {HI,LO} <= the 2*WIDTH-bit product (two's complement for MULT).
- Divide: restoring, one quotient bit per RUN cycle. LO <= quotient and HI <= remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of -2^(WIDTH-1) by -1: LO=0x80000000 and HI=0 (WIDTH=32).
- Divide by zero: accepted and bypasses RUN, going IDLE->FIX directly. HI/LO are left unchanged; done and div_by_zero pulse.
- start while busy=1 is ignored entirely. The requester holds start until it observes busy=0.
- A reset assertion mid-operation aborts the operation; HI/LO clear to 0 and no done is issued.

## Timing
- Accepting edge is E0 (start=1, busy=0).
- Iterative mul/div: busy=1 from after E0 through E(WIDTH+1). HI/LO update at E(WIDTH+1), when busy falls and done=1 for that cycle. Total latency is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: busy=1 for one cycle after E0. At E1, done=1 and div_by_zero=1 for one cycle, and busy returns to 0.
- FAST_MUL=1 multiply: HI/LO written at E0, done=1 in the cycle after E0, and busy never asserts. Divide stays iterative.
- MTHI/MTLO: the write is visible on hi_reg/lo_reg the cycle after E0.
- Back-to-back: a new start may be accepted on the same edge at which done is high, since busy=0 by then.
- hi_reg/lo_reg are registered outputs and never show partial results.

## Test plan
- Reset and MTHI: reset low, then high; MTHI 0x12345678 -> hi_reg=0x12345678 next cycle, lo_reg=0, busy never set.
- Signed multiply: MULT 0xFFFFFFFE x 0x00000003 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, with a single done pulse.
- Unsigned multiply, same operands: MULTU 0xFFFFFFFE x 0x00000003 -> HI=0x00000002, LO=0xFFFFFFFA; with FAST_MUL=1, the same result with done one cycle after accept.
- Signed divide: DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DIVU 5 / 0 with HI=0xAA and LO=0xBB preloaded -> done and div_by_zero pulse at E1, HI/LO unchanged.
- Protocol: start asserted with busy=1 is ignored and the in-flight result is unaffected. Reset pulled low at cycle 10 of a DIVU -> busy=0 and HI=LO=0 immediately, with no done pulse.
